// File: rtl/axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_pkg : AXI-lite request/response bundles and arbiter state type   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [ADDR_W-1:0] araddr;
        logic              arvalid;
        logic              rready;
        logic [ADDR_W-1:0] awaddr;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wvalid;
        logic              bready;
    } axi_req_t;

    typedef struct packed {
        logic              arready;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rvalid;
        logic              awready;
        logic              wready;
        logic              bvalid;
        logic [1:0]        bresp;
    } axi_rsp_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : round-robin winner search starting just above rr_ptr       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic                   valid,
    output logic [IDX_W-1:0]       winner
);

    logic [IDX_W-1:0] idx;

    // Walk from lowest to highest priority so the nearest requester above rr_ptr wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_arbiter : shares one AXI-lite slave between NUM_MASTERS     |
// | requesters, one whole transaction at a time, round-robin. rev 1.0    |
// +----------------------------------------------------------------------+
module axi_lite_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  axi_req_t               m_req [NUM_MASTERS],
    output axi_rsp_t               m_rsp [NUM_MASTERS],
    output axi_req_t               s_req,
    input  axi_rsp_t               s_rsp,
    output logic [NUM_MASTERS-1:0] grant
);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   a_done_q, a_done_d;
    logic                   w_done_q, w_done_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;

    logic [NUM_MASTERS-1:0] req_vec;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    axi_req_t               g_req;
    logic                   ar_hs, aw_hs, w_hs, r_hs, b_hs;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_req_vec
        assign req_vec[i] = m_req[i].arvalid | m_req[i].awvalid;
    end

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .req    (req_vec),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    assign g_req = m_req[gidx_q];

    // Handshakes are judged on the forwarded (gated) slave-side signals.
    assign ar_hs = s_req.arvalid & s_rsp.arready;
    assign aw_hs = s_req.awvalid & s_rsp.awready;
    assign w_hs  = s_req.wvalid  & s_rsp.wready;
    assign r_hs  = s_rsp.rvalid  & g_req.rready;
    assign b_hs  = s_rsp.bvalid  & g_req.bready;

    always_comb begin
        state_d  = state_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        a_done_d = a_done_q;
        w_done_d = w_done_q;
        grant_d  = grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d           = m_req[pick_idx].awvalid ? ARB_WR : ARB_RD;
                    gidx_d            = pick_idx;
                    rr_ptr_d          = pick_idx;
                    a_done_d          = 1'b0;
                    w_done_d          = 1'b0;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            ARB_RD: begin
                if (ar_hs) a_done_d = 1'b1;
                if (r_hs) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            ARB_WR: begin
                if (aw_hs) a_done_d = 1'b1;
                if (w_hs)  w_done_d = 1'b1;
                if (b_hs) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= ARB_IDLE;
            gidx_q   <= '0;
            rr_ptr_q <= IDX_W'(NUM_MASTERS - 1);
            a_done_q <= 1'b0;
            w_done_q <= 1'b0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            a_done_q <= a_done_d;
            w_done_q <= w_done_d;
            grant_q  <= grant_d;
        end
    end

    assign grant = grant_q;

    // Channel muxing: only the owner's channels are connected, everything else reads 0.
    always_comb begin
        s_req = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rsp[i] = '0;
        end
        case (state_q)
            ARB_RD: begin
                s_req.araddr  = g_req.araddr;
                s_req.arvalid = g_req.arvalid & ~a_done_q;
                s_req.rready  = g_req.rready;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (IDX_W'(i) == gidx_q) begin
                        m_rsp[i].arready = s_rsp.arready & ~a_done_q;
                        m_rsp[i].rdata   = s_rsp.rdata;
                        m_rsp[i].rresp   = s_rsp.rresp;
                        m_rsp[i].rvalid  = s_rsp.rvalid;
                    end
                end
            end
            ARB_WR: begin
                s_req.awaddr  = g_req.awaddr;
                s_req.awvalid = g_req.awvalid & ~a_done_q;
                s_req.wdata   = g_req.wdata;
                s_req.wstrb   = g_req.wstrb;
                s_req.wvalid  = g_req.wvalid & ~w_done_q;
                s_req.bready  = g_req.bready;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (IDX_W'(i) == gidx_q) begin
                        m_rsp[i].awready = s_rsp.awready & ~a_done_q;
                        m_rsp[i].wready  = s_rsp.wready & ~w_done_q;
                        m_rsp[i].bvalid  = s_rsp.bvalid;
                        m_rsp[i].bresp   = s_rsp.bresp;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_lite_arbiter : two master agents, SRAM-like slave, reference  |
// | model compared every cycle, plus directed scenario checks. rev 1.0   |
// +----------------------------------------------------------------------+
module tb_axi_lite_arbiter;
    import axi_pkg::*;

    localparam int NM = 2;

    logic          aclk = 1'b0;
    logic          areset;
    axi_req_t      m_req [NM];
    axi_rsp_t      m_rsp [NM];
    axi_req_t      s_req;
    axi_rsp_t      s_rsp;
    logic [NM-1:0] grant;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axi_lite_arbiter #(.NUM_MASTERS(NM)) dut (
        .aclk   (aclk),
        .areset (areset),
        .m_req  (m_req),
        .m_rsp  (m_rsp),
        .s_req  (s_req),
        .s_rsp  (s_rsp),
        .grant  (grant)
    );

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] slv_data(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 64'h0000_0000_0000_0413 : {32'hcafe_0000, a};
    endfunction

    function automatic logic [1:0] slv_resp(input logic [31:0] a);
        return a[2] ? 2'b10 : RESP_OKAY;
    endfunction

    // ---------------- slave: always ready, one-cycle read/write response
    logic        sl_aw, sl_w, sl_aw_hs, sl_w_hs;
    logic [31:0] sl_awaddr, sl_b_addr;
    logic [63:0] sl_wdata;
    logic [7:0]  sl_wstrb;
    assign sl_aw_hs  = s_req.awvalid & s_rsp.awready;
    assign sl_w_hs   = s_req.wvalid & s_rsp.wready;
    assign sl_b_addr = sl_aw_hs ? s_req.awaddr : sl_awaddr;

    always @(posedge aclk) begin
        if (areset) begin
            s_rsp     <= '0;
            sl_aw     <= 1'b0;
            sl_w      <= 1'b0;
            sl_awaddr <= '0;
            sl_wdata  <= '0;
            sl_wstrb  <= '0;
        end else begin
            s_rsp.arready <= 1'b1;
            s_rsp.awready <= 1'b1;
            s_rsp.wready  <= 1'b1;
            if (s_req.arvalid && s_rsp.arready) begin
                s_rsp.rvalid <= 1'b1;
                s_rsp.rdata  <= slv_data(s_req.araddr);
                s_rsp.rresp  <= slv_resp(s_req.araddr);
            end else if (s_rsp.rvalid && s_req.rready) begin
                s_rsp.rvalid <= 1'b0;
            end
            if (sl_aw_hs) sl_awaddr <= s_req.awaddr;
            if (sl_w_hs) begin
                sl_wdata <= s_req.wdata;
                sl_wstrb <= s_req.wstrb;
            end
            if (s_rsp.bvalid && s_req.bready) s_rsp.bvalid <= 1'b0;
            if ((sl_aw || sl_aw_hs) && (sl_w || sl_w_hs)) begin
                s_rsp.bvalid <= 1'b1;
                s_rsp.bresp  <= slv_resp(sl_b_addr);
                sl_aw        <= 1'b0;
                sl_w         <= 1'b0;
            end else begin
                if (sl_aw_hs) sl_aw <= 1'b1;
                if (sl_w_hs)  sl_w  <= 1'b1;
            end
        end
    end

    // ---------------- master agents fed from per-master op queues
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        int          delay;
    } op_t;

    op_t         q0[$], q1[$];
    bit          busy [NM];
    op_t         cur  [NM];
    bit          ar_p [NM], aw_p [NM], w_p [NM], rdy [NM];
    int          hold [NM];
    logic [63:0] last_rdata [NM];
    logic [1:0]  last_resp  [NM];
    int          done_cnt   [NM];

    task automatic push(input int m, input bit wr, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] s, input int dly);
        op_t o;
        o = '{wr, a, d, s, dly};
        if (m == 0) q0.push_back(o);
        else        q1.push_back(o);
    endtask

    initial begin
        for (int i = 0; i < NM; i++) begin
            m_req[i] = '0; busy[i] = 0; ar_p[i] = 0; aw_p[i] = 0; w_p[i] = 0;
            rdy[i] = 0; hold[i] = 0; done_cnt[i] = 0;
            last_rdata[i] = '0; last_resp[i] = '0;
        end
        forever begin
            @(negedge aclk);
            for (int i = 0; i < NM; i++) begin
                if (areset) begin
                    busy[i] = 0; ar_p[i] = 0; aw_p[i] = 0; w_p[i] = 0;
                    if (i == 0) q0.delete(); else q1.delete();
                end else begin
                    if (busy[i]) begin
                        if (ar_p[i] && m_rsp[i].arready) ar_p[i] = 0;
                        if (aw_p[i] && m_rsp[i].awready) aw_p[i] = 0;
                        if (w_p[i]  && m_rsp[i].wready)  w_p[i]  = 0;
                        if ((!cur[i].wr && m_rsp[i].rvalid) || (cur[i].wr && m_rsp[i].bvalid)) begin
                            if (rdy[i]) begin
                                last_rdata[i] = m_rsp[i].rdata;
                                last_resp[i]  = cur[i].wr ? m_rsp[i].bresp : m_rsp[i].rresp;
                                done_cnt[i]++;
                                busy[i] = 0;
                            end else begin
                                hold[i]--;
                                if (hold[i] <= 0) rdy[i] = 1;
                            end
                        end
                    end
                    if (!busy[i] && ((i == 0) ? q0.size() : q1.size()) > 0) begin
                        cur[i]  = (i == 0) ? q0.pop_front() : q1.pop_front();
                        busy[i] = 1;
                        ar_p[i] = !cur[i].wr;
                        aw_p[i] = cur[i].wr;
                        w_p[i]  = cur[i].wr;
                        hold[i] = cur[i].delay;
                        rdy[i]  = (cur[i].delay == 0);
                    end
                end
            end
            @(posedge aclk);
            #1;
            for (int i = 0; i < NM; i++) begin
                m_req[i] = '0;
                if (busy[i]) begin
                    m_req[i].araddr  = cur[i].wr ? 32'h0 : cur[i].addr;
                    m_req[i].arvalid = ar_p[i];
                    m_req[i].rready  = !cur[i].wr && rdy[i];
                    m_req[i].awaddr  = cur[i].wr ? cur[i].addr : 32'h0;
                    m_req[i].awvalid = aw_p[i];
                    m_req[i].wdata   = cur[i].data;
                    m_req[i].wstrb   = cur[i].strb;
                    m_req[i].wvalid  = w_p[i];
                    m_req[i].bready  = cur[i].wr && rdy[i];
                end
            end
        end
    end

    // ---------------- reference model: owner index, last winner, sub-channel progress
    logic [NM-1:0] glog[$];

    initial begin
        int            owner, last, c;
        bit            mwr, a_seen, w_seen, live, prev_ok;
        axi_req_t      es, mq;
        axi_rsp_t      er [NM];
        axi_req_t      prev_m [NM];
        axi_rsp_t      prev_r [NM];
        logic [NM-1:0] eg;
        owner = -1; last = NM - 1; mwr = 0; a_seen = 0; w_seen = 0; live = 0; prev_ok = 0;
        forever begin
            @(negedge aclk);
            if (live) begin
                eg = '0;
                es = '0;
                for (int i = 0; i < NM; i++) er[i] = '0;
                if (owner >= 0) begin
                    eg[owner] = 1'b1;
                    mq = m_req[owner];
                    if (!mwr) begin
                        es.araddr  = mq.araddr;
                        es.arvalid = mq.arvalid && !a_seen;
                        es.rready  = mq.rready;
                        er[owner].arready = s_rsp.arready && !a_seen;
                        er[owner].rdata   = s_rsp.rdata;
                        er[owner].rresp   = s_rsp.rresp;
                        er[owner].rvalid  = s_rsp.rvalid;
                    end else begin
                        es.awaddr  = mq.awaddr;
                        es.awvalid = mq.awvalid && !a_seen;
                        es.wdata   = mq.wdata;
                        es.wstrb   = mq.wstrb;
                        es.wvalid  = mq.wvalid && !w_seen;
                        es.bready  = mq.bready;
                        er[owner].awready = s_rsp.awready && !a_seen;
                        er[owner].wready  = s_rsp.wready && !w_seen;
                        er[owner].bvalid  = s_rsp.bvalid;
                        er[owner].bresp   = s_rsp.bresp;
                    end
                end
                chk("model_grant", grant, eg);
                chk("model_s_req", s_req, es);
                chk("model_m_rsp0", m_rsp[0], er[0]);
                chk("model_m_rsp1", m_rsp[1], er[1]);
                glog.push_back(grant);
                // A master must hold a valid until its handshake.
                if (prev_ok && !areset) begin
                    for (int i = 0; i < NM; i++) begin
                        if (prev_m[i].arvalid && !prev_r[i].arready)
                            chk("protocol_arvalid_held", m_req[i].arvalid, 1'b1);
                        if (prev_m[i].awvalid && !prev_r[i].awready)
                            chk("protocol_awvalid_held", m_req[i].awvalid, 1'b1);
                        if (prev_m[i].wvalid && !prev_r[i].wready)
                            chk("protocol_wvalid_held", m_req[i].wvalid, 1'b1);
                    end
                end
                // Advance the model to the next cycle.
                if (areset) begin
                    owner = -1; last = NM - 1; a_seen = 0; w_seen = 0;
                end else if (owner < 0) begin
                    for (int k = 1; k <= NM; k++) begin
                        c = (last + k) % NM;
                        if (owner < 0 && (m_req[c].arvalid || m_req[c].awvalid)) begin
                            owner = c; mwr = m_req[c].awvalid; last = c; a_seen = 0; w_seen = 0;
                        end
                    end
                end else if (!mwr) begin
                    if (m_req[owner].arvalid && !a_seen && s_rsp.arready) a_seen = 1;
                    if (s_rsp.rvalid && m_req[owner].rready) owner = -1;
                end else begin
                    if (m_req[owner].awvalid && !a_seen && s_rsp.awready) a_seen = 1;
                    if (m_req[owner].wvalid && !w_seen && s_rsp.wready) w_seen = 1;
                    if (s_rsp.bvalid && m_req[owner].bready) owner = -1;
                end
            end else if (areset) begin
                live = 1; owner = -1; last = NM - 1; a_seen = 0; w_seen = 0;
            end
            for (int i = 0; i < NM; i++) begin
                prev_m[i] = m_req[i];
                prev_r[i] = m_rsp[i];
            end
            prev_ok = live && !areset;
        end
    end

    // ---------------- directed scenarios
    logic [NM-1:0] ctr[$];
    logic [NM-1:0] nz[$];

    task automatic compress_log();
        ctr.delete();
        nz.delete();
        foreach (glog[k]) begin
            if (ctr.size() == 0) begin
                if (glog[k] != '0) ctr.push_back(glog[k]);
            end else if (glog[k] != ctr[ctr.size()-1]) begin
                ctr.push_back(glog[k]);
            end
        end
        foreach (ctr[k]) if (ctr[k] != '0) nz.push_back(ctr[k]);
    endtask

    task automatic wait_grant(input logic [NM-1:0] g, input string name);
        int t;
        t = 0;
        while (grant !== g && t < 40) begin
            @(negedge aclk);
            t++;
        end
        chk(name, grant, g);
    endtask

    task automatic wait_done(input int m, input int n, input string name);
        int t;
        t = 0;
        while (done_cnt[m] < n && t < 400) begin
            @(negedge aclk);
            t++;
        end
        chk(name, done_cnt[m] >= n, 1'b1);
    endtask

    task automatic cycle_drive();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int          t, g01, m1rv, stall, n0, n1;
        bit          fin;
        logic [63:0] exp_rd;
        areset = 1'b1;
        repeat (3) cycle_drive();
        @(negedge aclk);
        chk("reset_grant", grant, 2'b00);
        chk("reset_s_req", s_req, '0);
        chk("reset_m_rsp0", m_rsp[0], '0);
        chk("reset_m_rsp1", m_rsp[1], '0);
        cycle_drive();
        areset = 1'b0;
        repeat (2) cycle_drive();

        // single read from m0
        n0 = done_cnt[0]; g01 = 0; m1rv = 0; t = 0;
        push(0, 0, 32'h8000_0000, 64'h0, 8'h0, 0);
        while (done_cnt[0] == n0 && t < 50) begin
            @(negedge aclk);
            t++;
            if (grant == 2'b01) g01++;
            if (m_rsp[1].rvalid) m1rv++;
        end
        chk("single_read_done", done_cnt[0], n0 + 1);
        chk("single_read_rdata", last_rdata[0], 64'h413);
        chk("single_read_rresp", last_resp[0], RESP_OKAY);
        chk("single_read_grant_cycles", g01, 2);
        chk("single_read_m1_rvalid", m1rv, 0);
        repeat (3) cycle_drive();

        // simultaneous reads right after reset
        areset = 1'b1;
        cycle_drive();
        areset = 1'b0;
        glog.delete();
        n0 = done_cnt[0]; n1 = done_cnt[1];
        push(0, 0, 32'h8000_0010, 64'h0, 8'h0, 0);
        push(1, 0, 32'h8000_0020, 64'h0, 8'h0, 0);
        wait_done(0, n0 + 1, "simul_m0_done");
        wait_done(1, n1 + 1, "simul_m1_done");
        repeat (2) @(negedge aclk);
        compress_log();
        chk("simul_seq_len", ctr.size(), 4);
        if (ctr.size() >= 4)
            chk("simul_grant_seq", {ctr[0], ctr[1], ctr[2], ctr[3]}, 8'b01_00_10_00);
        chk("simul_m1_rdata", last_rdata[1], slv_data(32'h8000_0020));
        cycle_drive();

        // continuous requests: strict alternation over 10 transactions
        glog.delete();
        n0 = done_cnt[0]; n1 = done_cnt[1];
        for (int k = 0; k < 5; k++) begin
            push(0, 0, 32'h8000_0200 + 32'(k * 16), 64'h0, 8'h0, 0);
            push(1, 0, 32'h8000_0280 + 32'(k * 16), 64'h0, 8'h0, 0);
        end
        wait_done(0, n0 + 5, "alt_m0_done");
        wait_done(1, n1 + 5, "alt_m1_done");
        repeat (2) @(negedge aclk);
        compress_log();
        chk("alt_count", nz.size(), 10);
        for (int k = 0; k < 10 && k < nz.size(); k++)
            chk($sformatf("alt_grant_%0d", k), nz[k], (k % 2) ? 2'b10 : 2'b01);
        chk("alt_m0_rdata", last_rdata[0], slv_data(32'h8000_0240));
        chk("alt_m1_rdata", last_rdata[1], slv_data(32'h8000_02c0));
        cycle_drive();

        // m1 write with bready held low, m0 read waiting
        n0 = done_cnt[0];
        push(1, 1, 32'h8000_1000, 64'h0000_0000_dead_beef, 8'h0f, 3);
        wait_grant(2'b10, "wr_granted");
        push(0, 0, 32'h8000_0040, 64'h0, 8'h0, 0);
        stall = 0; fin = 0; t = 0;
        while (!fin && t < 30) begin
            @(negedge aclk);
            t++;
            chk("wr_grant_hold", grant, 2'b10);
            chk("wr_m0_arready_blocked", m_rsp[0].arready, 1'b0);
            if (m_rsp[1].bvalid) begin
                if (m_req[1].bready) fin = 1;
                else stall++;
            end
        end
        chk("wr_b_handshake", fin, 1'b1);
        chk("wr_bvalid_stall_cycles", stall, 3);
        @(negedge aclk);
        chk("wr_gap_idle", grant, 2'b00);
        @(negedge aclk);
        chk("wr_then_m0", grant, 2'b01);
        chk("wr_slave_awaddr", sl_awaddr, 32'h8000_1000);
        chk("wr_slave_wdata", sl_wdata, 64'h0000_0000_dead_beef);
        chk("wr_slave_wstrb", sl_wstrb, 8'h0f);
        chk("wr_bresp", last_resp[1], RESP_OKAY);
        wait_done(0, n0 + 1, "wr_m0_read_done");
        cycle_drive();

        // rready held low for 4 cycles, slave returns an error response
        exp_rd = slv_data(32'h8000_0104);
        push(0, 0, 32'h8000_0104, 64'h0, 8'h0, 4);
        stall = 0; fin = 0; t = 0;
        while (!fin && t < 40) begin
            @(negedge aclk);
            t++;
            if (m_rsp[0].rvalid) begin
                chk("hold_rdata_stable", m_rsp[0].rdata, exp_rd);
                chk("hold_grant", grant, 2'b01);
                if (m_req[0].rready) fin = 1;
                else stall++;
            end
        end
        chk("hold_r_handshake", fin, 1'b1);
        chk("hold_stall_cycles", stall, 4);
        @(negedge aclk);
        chk("hold_idle_after", grant, 2'b00);
        chk("hold_rresp_passthru", last_resp[0], 2'b10);
        cycle_drive();

        // reset in the middle of a read
        push(1, 0, 32'h8000_0300, 64'h0, 8'h0, 10);
        wait_grant(2'b10, "rst_rd_granted");
        cycle_drive();
        areset = 1'b1;
        cycle_drive();
        areset = 1'b0;
        @(negedge aclk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_arvalid", s_req.arvalid, 1'b0);
        chk("rst_awvalid", s_req.awvalid, 1'b0);
        chk("rst_wvalid", s_req.wvalid, 1'b0);
        cycle_drive();
        glog.delete();
        n0 = done_cnt[0]; n1 = done_cnt[1];
        push(1, 0, 32'h8000_0310, 64'h0, 8'h0, 0);
        push(0, 0, 32'h8000_0318, 64'h0, 8'h0, 0);
        wait_done(0, n0 + 1, "rst_m0_done");
        wait_done(1, n1 + 1, "rst_m1_done");
        compress_log();
        if (nz.size() >= 1) chk("rst_first_winner", nz[0], 2'b01);
        else                chk("rst_first_winner", 2'b00, 2'b01);

        repeat (3) @(negedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
